// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the multi-cycle restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;

    // When the subtraction succeeds the result is below the divisor, so WIDTH+1 bits suffice.
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {2'b00, divisor});
        diff    = shifted[WIDTH:0] - {1'b0, divisor};
        rem_out = q_bit ? diff : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Parametrised multi-cycle signed/unsigned restoring divider with busy/done handshake and divide-by-zero flag.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               dbz_q, dbz_d;

    logic               accept, b_zero, last;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     step_rem;
    logic               step_bit;
    logic [WIDTH-1:0]   quo_mag, rem_mag;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .divisor (div_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state logic; DONE accepts a new start exactly like IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = b_zero ? DONE : RUN;
                else       state_d = IDLE;
            end
            RUN:     if (last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        dbz  = dbz_q;
        q    = q_q;
        r    = r_q;
    end

    always_comb begin
        accept  = start && (state_q != RUN);
        b_zero  = (b == '0);
        last    = (cnt_q == CNT_W'(1));
        a_neg   = signed_mode && a[WIDTH-1];
        b_neg   = signed_mode && b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        quo_mag = {dvd_q[WIDTH-2:0], step_bit};
        rem_mag = step_rem[WIDTH-1:0];
    end

    // Dividend register doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom.
    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        if (accept) begin
            if (b_zero) begin
                q_d   = '1;
                r_d   = a;
                dbz_d = 1'b1;
            end else begin
                cnt_d   = CNT_W'(WIDTH);
                rem_d   = '0;
                dvd_d   = a_mag;
                div_d   = b_mag;
                neg_q_d = a_neg ^ b_neg;
                neg_r_d = a_neg;
            end
        end
        if (state_q == RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            rem_d = step_rem;
            dvd_d = quo_mag;
            if (last) begin
                q_d   = neg_q_q ? -quo_mag : quo_mag;
                r_d   = neg_r_q ? -rem_mag : rem_mag;
                dbz_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a 32-bit and an 8-bit instance checked against hand-computed results.
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start32 = 1'b0;
    logic        start8 = 1'b0;
    logic        signed_mode = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        busy32, done32, dbz32;
    logic [31:0] q32, r32;
    logic        busy8, done8, dbz8;
    logic [7:0]  q8, r8;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    bit use8 = 1'b0;

    logic        busy_s, done_s, dbz_s;
    logic [31:0] q_s, r_s;

    seq_divider #(.WIDTH(32)) dut32 (
        .clock       (clock),
        .reset       (reset),
        .start       (start32),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy32),
        .done        (done32),
        .dbz         (dbz32),
        .q           (q32),
        .r           (r32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .start       (start8),
        .signed_mode (signed_mode),
        .a           (a[7:0]),
        .b           (b[7:0]),
        .busy        (busy8),
        .done        (done8),
        .dbz         (dbz8),
        .q           (q8),
        .r           (r8)
    );

    assign busy_s = use8 ? busy8 : busy32;
    assign done_s = use8 ? done8 : done32;
    assign dbz_s  = use8 ? dbz8  : dbz32;
    assign q_s    = use8 ? {24'h0, q8} : q32;
    assign r_s    = use8 ? {24'h0, r8} : r32;

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts an operation in the current cycle and follows it to done (bounded).
    task automatic run_op(input string tag, input bit w8, input bit sm,
                          input logic [31:0] av, input logic [31:0] bv,
                          input int exp_lat, input int exp_busy,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        int lat;
        int nbusy;
        use8 = w8;
        signed_mode = sm;
        a = av;
        b = bv;
        if (w8) start8 = 1'b1;
        else    start32 = 1'b1;
        lat = -1;
        nbusy = 0;
        for (int c = 1; c <= 100; c++) begin
            step();
            start8 = 1'b0;
            start32 = 1'b0;
            if (busy_s) nbusy++;
            if (done_s) begin
                lat = c;
                break;
            end
        end
        check({tag, " done_cycle"}, lat, exp_lat);
        check({tag, " busy_cycles"}, nbusy, exp_busy);
        check({tag, " busy_at_done"}, {31'h0, busy_s}, 32'h0);
        check({tag, " q"}, q_s, eq);
        check({tag, " r"}, r_s, er);
        check({tag, " dbz"}, {31'h0, dbz_s}, {31'h0, edbz});
    endtask

    initial begin
        int lat;
        step();
        step();
        // reset state, sampled while reset is still held
        check("rst busy32", {31'h0, busy32}, 32'h0);
        check("rst done32", {31'h0, done32}, 32'h0);
        check("rst dbz32", {31'h0, dbz32}, 32'h0);
        check("rst q32", q32, 32'h0);
        check("rst r32", r32, 32'h0);
        check("rst q8", {24'h0, q8}, 32'h0);
        reset = 1'b0;
        step();

        run_op("u100/7", 1'b0, 1'b0, 32'd100, 32'd7, 33, 32, 32'd14, 32'd2, 1'b0);
        step();
        run_op("s-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_op("s-100/7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 33, 32, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        step();
        run_op("u5/0", 1'b0, 1'b0, 32'd5, 32'd0, 1, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_op("s5/0", 1'b0, 1'b1, 32'd5, 32'd0, 1, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_op("u9/3", 1'b0, 1'b0, 32'd9, 32'd3, 33, 32, 32'd3, 32'd0, 1'b0);
        step();

        // start while busy is ignored; results hold until the next done
        use8 = 1'b0;
        signed_mode = 1'b0;
        a = 32'd50;
        b = 32'd5;
        start32 = 1'b1;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            step();
            start32 = 1'b0;
            if (c == 10) begin
                check("busy_c10", {31'h0, busy32}, 32'h1);
                check("hold_q_c10", q32, 32'd3);
                a = 32'd1;
                b = 32'd1;
                start32 = 1'b1;
            end
            if (done32) begin
                lat = c;
                break;
            end
        end
        check("ign done_cycle", lat, 33);
        check("ign q", q32, 32'd10);
        check("ign r", r32, 32'd0);
        // start in the done cycle: no bubble, next done at cycle 66
        run_op("b2b20/3", 1'b0, 1'b0, 32'd20, 32'd3, 33, 32, 32'd6, 32'd2, 1'b0);
        step();

        run_op("w8 s-128/-1", 1'b1, 1'b1, 32'h80, 32'hFF, 9, 8, 32'h80, 32'h00, 1'b0);
        run_op("w8 uFF/1", 1'b1, 1'b0, 32'hFF, 32'h01, 9, 8, 32'hFF, 32'h00, 1'b0);
        run_op("w8 u200/7", 1'b1, 1'b0, 32'd200, 32'd7, 9, 8, 32'd28, 32'd4, 1'b0);
        step();

        // reset in cycle 5 of an operation
        use8 = 1'b0;
        signed_mode = 1'b0;
        a = 32'd77;
        b = 32'd4;
        start32 = 1'b1;
        step();
        start32 = 1'b0;
        for (int c = 2; c <= 5; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst busy c6", {31'h0, busy32}, 32'h0);
        check("mrst done c6", {31'h0, done32}, 32'h0);
        check("mrst q c6", q32, 32'h0);
        check("mrst r c6", r32, 32'h0);
        step();
        check("mrst busy c7", {31'h0, busy32}, 32'h0);
        check("mrst done c7", {31'h0, done32}, 32'h0);
        run_op("post_rst1000/10", 1'b0, 1'b0, 32'd1000, 32'd10, 33, 32, 32'd100, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised multi-cycle restoring divider; successor to the fixed 32-bit unsigned Division block.
- Generalised operand width.
- Per-operation signed/unsigned mode.
- Explicit busy/done handshake and a divide-by-zero flag.
- Sits beside the existing arithmetic blocks. Driven by a controller that pulses start and waits for done.

Parameters:
WIDTH, 32, operand/result width in bits (≥2)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
a  input  WIDTH  dividend; sampled with start
b  input  WIDTH  divisor; sampled with start
busy  output  1  iteration in progress, new start ignored
done  output  1  one-cycle pulse, q/r/dbz valid
dbz  output  1  last operation had b==0
q  output  WIDTH  quotient
r  output  WIDTH  remainder

Behaviour:
- Reset (synchronous, active-high, wins over everything): state=IDLE, busy=0, done=0, dbz=0, q=0, r=0. Also applies mid-operation; the in-flight result is discarded.
- States:
  - IDLE: start=1 at an edge latches a, b and signed_mode → RUN. If b==0 it goes → DONE instead.
  - RUN: one quotient bit per cycle, MSB first, using a WIDTH-bit down-counter. After exactly WIDTH RUN cycles → DONE.
  - DONE: done=1 for this one cycle. Behaves like IDLE: start here is accepted with the same rules and no bubble.
- Timing, with start high in cycle 0:
  - busy=1 in cycles 1..WIDTH.
  - done=1 in cycle WIDTH+1.
  - busy=0 in the DONE cycle.
- Divide by zero: start in cycle 0 gives done=1 in cycle 1, with busy never asserted. Results: q = all ones, r = a unchanged (raw bits, both modes), dbz=1.
- q, r and dbz update only when done rises. They hold until the next done; they do not change on start.
- Arithmetic:
  - Unsigned mode: plain restoring division on WIDTH-bit values.
  - Signed mode: divide the magnitudes, then negate q if sign(a)≠sign(b) and negate r if a<0. This truncates toward zero; r takes the sign of a, or is 0.
  - Internal partial remainder is WIDTH+1 bits, so no magnitude overflows.
  - Signed most-negative / -1 yields q = most-negative (wrap) and r=0, dbz=0.
- start while busy=1: ignored, operands not re-latched, no error flag.
- start held high continuously: a new operation starts after every done cycle.

Decomposition:
- Shared package seq_divider_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Counter width constant $clog2(WIDTH+1).
- One sub-module, div_step: combinational single restoring step.
  - In: partial remainder (WIDTH+1), divisor magnitude, next dividend bit.
  - Out: new partial remainder, quotient bit.
- Top level holds the FSM, the operand and sign registers, the counter and the output registers.

Test Plan:
- WIDTH=32, unsigned, a=100, b=7, start in cycle 0 → busy cycles 1..32; done only in cycle 33; q=14, r=2, dbz=0.
- WIDTH=32, signed, a=-7 (0xFFFFFFF9), b=2 → q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Then a=7, b=-2 → q=-3, r=1.
- WIDTH=32, a=5, b=0 (both modes) → done in cycle 1, busy never high; q=0xFFFFFFFF, r=5, dbz=1. Next op 9/3 clears dbz: q=3, r=0.
- WIDTH=32: start 50/5, then pulse start with 1/1 in cycle 10 → second start ignored. done in cycle 33 gives q=10, r=0. Start asserted in the done cycle is accepted; its done falls in cycle 66.
- WIDTH=8, signed, a=0x80 (-128), b=0xFF (-1) → done in cycle 9; q=0x80, r=0x00. Unsigned 0xFF/0x01 → q=0xFF, r=0.
- Reset asserted in cycle 5 of a WIDTH=32 op → busy=0, done=0, q=r=0 from cycle 6; no done follows. A fresh start in cycle 7 completes normally, with done in cycle 40.
